// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, stalls on the memory handshake and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t state_q;
    state_t state_d;
    logic   retire;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = FETCH;
        retire     = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            // The write strobe stays up for the whole wait so slow memories see a stable request.
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
                retire   = mem_ready;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
                retire  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // In reset every output looks like an idle FETCH so no write can leak out mid-instruction.
        if (!rst_n) begin
            retire     = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            PCSrc      = 2'b00;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            ALUOp      = 2'b00;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It sits directly upstream of the ALU decoder and drives its 2-bit ALUOp; the decoder combines ALUOp with funct to produce ALUControl. The FSM decodes op[5:0] from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback. It also handles a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
op  in  6  opcode from the instruction register (stable from DECODE until the return to FETCH)
mem_ready  in  1  memory handshake; high = current access completes this cycle
IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC load
Branch  out  1  conditional PC load (datapath ANDs it with Zero)
PCSrc  out  2  PC source (00 = ALUResult, 01 = ALUOut, 10 = jump target)
ALUSrcA  out  1  ALU A select (0 = PC, 1 = register A)
ALUSrcB  out  2  ALU B select (00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2)
ALUOp  out  2  to ALU decoder (00 = add, 01 = sub, 10 = use funct)
RegDst  out  1  register write destination (0 = rt, 1 = rd)
MemtoReg  out  1  register write data select (0 = ALUOut, 1 = Data)
RegWrite  out  1  register file write enable
illegal_op  out  1  high in DECODE when op is unsupported
state  out  4  current state encoding, for debug
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- The FSM is Moore, with one exception: FETCH, MEMRD and MEMWR qualify their outputs and transitions with mem_ready. Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are illegal and go to FETCH on the next edge with all outputs 0.
- Reset: when rst_n=0 at a clock edge, state<=FETCH and instr_count<=0.
  - While rst_n=0, MemWrite, IRWrite, PCWrite, Branch and RegWrite are forced to 0 combinationally.
  - The mux selects show FETCH values: ALUSrcB=01, others 0.
- FETCH: ALUSrcB=01; IRWrite=PCWrite=mem_ready. Goes to DECODE if mem_ready, otherwise stays in FETCH.
- DECODE: ALUSrcB=11. Next state by op:
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x00 (R-type) -> EXECUTE
  - 0x04 (beq) -> BRANCH
  - 0x08 (addi) -> ADDIEX
  - 0x02 (j) -> JUMP
  - anything else -> FETCH with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD if op=0x23, otherwise MEMWR.
- MEMRD: IorD=1. Goes to MEMWB on mem_ready, otherwise holds.
- MEMWB: MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1, held every cycle while waiting. Goes to FETCH on mem_ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB.
- ADDIWB: RegWrite=1. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, BRANCH, ADDIWB or JUMP.
  - It does not increment on the illegal-op path or on recovery from an illegal state code.
  - It wraps modulo 2^CNT_W.
- Latency, mem_ready held high: lw=5 cycles, sw=4, R-type=4, addi=4, beq=3, j=3.
- Reset mid-instruction: the next edge returns to FETCH; no write enable is asserted during the reset cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with mem_ready=1 -> state=0, IRWrite=PCWrite=RegWrite=MemWrite=0, instr_count=0, ALUSrcB=01.
- R-type, op=0x00, mem_ready=1 -> states 0,1,6,7,0; ALUOp=10 only in EXECUTE; RegDst=RegWrite=1 in ALUWB; instr_count=1.
- lw, op=0x23, with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemtoReg=RegWrite=1 in MEMWB; total 7 cycles.
- sw, op=0x2B, mem_ready low for 1 cycle in MEMWR -> MemWrite=1 for 2 consecutive cycles with IorD=1; RegWrite never asserted.
- beq (0x04) then j (0x02) -> BRANCH shows ALUOp=01, Branch=1, PCSrc=01; JUMP shows PCWrite=1, PCSrc=10; instr_count increments by 2.
- op=0x3F -> illegal_op=1 in DECODE, next state=FETCH, instr_count unchanged. Separately, assert rst_n=0 while in MEMWR -> MemWrite=0 that cycle, state=0 next.
